// File: rtl/turbo_fetch_pkg.sv
// Shared types and constants for the Turboencabulator instruction fetch path.
package turbo_fetch_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int INSTR_W     = 32;

  localparam logic [INSTR_W-1:0]     NOP_WORD  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0]     HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [IMEM_ADDR_W-1:0] RESET_PC  = 10'd0;

  localparam int FETCH_CNT_W    = 32;
  localparam int REDIRECT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/redirect event counters, cleared only by reset.
module fetch_perf_counters
  import turbo_fetch_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_evt,
  input  logic                      redirect_evt,
  output logic [FETCH_CNT_W-1:0]    fetch_count,
  output logic [REDIRECT_CNT_W-1:0] redirect_count
);

  logic [FETCH_CNT_W-1:0]    fetch_count_q, fetch_count_d;
  logic [REDIRECT_CNT_W-1:0] redirect_count_q, redirect_count_d;

  // Next-count logic: increment on an event unless already at all-ones.
  always_comb begin
    fetch_count_d    = fetch_count_q;
    redirect_count_d = redirect_count_q;
    if (fetch_evt && (fetch_count_q != {FETCH_CNT_W{1'b1}})) begin
      fetch_count_d = fetch_count_q + 1'b1;
    end
    if (redirect_evt && (redirect_count_q != {REDIRECT_CNT_W{1'b1}})) begin
      redirect_count_d = redirect_count_q + 1'b1;
    end
  end

  // Counter registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q    <= '0;
      redirect_count_q <= '0;
    end else begin
      fetch_count_q    <= fetch_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign fetch_count    = fetch_count_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC into a combinational-read
// instruction memory and registers each returned word for decode.
// Optional feature macro: PERF_COUNT_EN (fetch/redirect counters).
module imem_fetch_ctrl
  import turbo_fetch_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Start,
  input  logic                      Stall,
  input  logic                      Redirect,
  input  logic [IMEM_ADDR_W-1:0]    RedirectTarget,
  input  logic [INSTR_W-1:0]        IMemData,
  output logic [IMEM_ADDR_W-1:0]    ProgCounter,
  output logic [INSTR_W-1:0]        Instr,
  output logic [IMEM_ADDR_W-1:0]    InstrPC,
  output logic                      InstrValid,
  output logic                      Halted,
  output logic [FETCH_CNT_W-1:0]    FetchCount,
  output logic [REDIRECT_CNT_W-1:0] RedirectCount
);

  fetch_state_e           state_q, state_d;
  logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;
  logic [IMEM_ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   halted_q, halted_d;

  // Next-state and next-output decision; in RUN: redirect > stall > halt > fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        if (Redirect) begin
          // Squash whatever was in flight; target word arrives next cycle.
          pc_d          = RedirectTarget;
          instr_d       = NOP_WORD;
          instr_valid_d = 1'b0;
        end else if (Stall) begin
          // Decode not ready: everything holds, valid included.
        end else if (IMemData == HALT_WORD) begin
          // PC stays parked on the halt word, which is never delivered.
          state_d       = HALTED;
          instr_valid_d = 1'b0;
          halted_d      = 1'b1;
        end else begin
          instr_d       = IMemData;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 1'b1;
        end
      end
      HALTED: begin
        instr_valid_d = 1'b0;
        if (Start) begin
          state_d  = RUN;
          pc_d     = RESET_PC;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fetch FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_WORD;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign ProgCounter = pc_q;
  assign Instr       = instr_q;
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = instr_valid_q;
  assign Halted      = halted_q;

`ifdef PERF_COUNT_EN
  logic fetch_evt;
  logic redirect_evt;

  // A delivery is exactly the fetch branch of the RUN priority chain.
  assign fetch_evt    = (state_q == RUN) && !Redirect && !Stall && (IMemData != HALT_WORD);
  assign redirect_evt = (state_q == RUN) && Redirect;

  fetch_perf_counters u_perf (
    .clk            (clk),
    .reset          (reset),
    .fetch_evt      (fetch_evt),
    .redirect_evt   (redirect_evt),
    .fetch_count    (FetchCount),
    .redirect_count (RedirectCount)
  );
`else
  assign FetchCount    = '0;
  assign RedirectCount = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed vector table, hand
// sequences for redirect/wrap/reset corners, and randomized run against
// a behavioural model. Honours PERF_COUNT_EN for counter expectations.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, Start, Stall, Redirect;
  logic [9:0]  RedirectTarget;
  logic [31:0] IMemData;
  logic [9:0]  ProgCounter, InstrPC;
  logic [31:0] Instr;
  logic        InstrValid, Halted;
  logic [31:0] FetchCount;
  logic [15:0] RedirectCount;

  logic [31:0] mem [0:1023];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign IMemData = mem[ProgCounter];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .Start          (Start),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .IMemData       (IMemData),
    .ProgCounter    (ProgCounter),
    .Instr          (Instr),
    .InstrPC        (InstrPC),
    .InstrValid     (InstrValid),
    .Halted         (Halted),
    .FetchCount     (FetchCount),
    .RedirectCount  (RedirectCount)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for Start, 1 = fetching, 2 = stopped on halt word
  int          m_mode;
  int          m_pc, m_ipc;
  logic [31:0] m_instr;
  bit          m_valid, m_halted;
  longint      m_fc, m_rc;

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_pc = 0; m_instr = 0; m_ipc = 0;
      m_valid = 0; m_halted = 0; m_fc = 0; m_rc = 0;
    end else if (m_mode == 0) begin
      if (Start) begin m_mode = 1; m_pc = 0; end
    end else if (m_mode == 1) begin
      if (Redirect) begin
        m_pc = int'(RedirectTarget); m_instr = 0; m_valid = 0;
        if (m_rc < 65535) m_rc++;
      end else if (Stall) begin
        // nothing moves
      end else if (mem[m_pc] == HALT) begin
        m_mode = 2; m_valid = 0; m_halted = 1;
      end else begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1;
        m_pc = (m_pc + 1) % 1024;
        if (m_fc < 64'hFFFF_FFFF) m_fc++;
      end
    end else begin
      m_valid = 0;
      if (Start) begin m_mode = 1; m_pc = 0; m_halted = 0; end
    end
  endtask

  // One clock: advance the model on the pre-edge inputs, then let the DUT clock.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},     {22'd0, ProgCounter}, 32'(m_pc));
    chk({tag, ".instr"},  Instr, m_instr);
    chk({tag, ".ipc"},    {22'd0, InstrPC}, 32'(m_ipc));
    chk({tag, ".valid"},  {31'd0, InstrValid}, {31'd0, m_valid});
    chk({tag, ".halted"}, {31'd0, Halted}, {31'd0, m_halted});
    chk({tag, ".fcnt"},   FetchCount, PERF ? 32'(m_fc) : 32'd0);
    chk({tag, ".rcnt"},   {16'd0, RedirectCount}, PERF ? 32'(m_rc) : 32'd0);
  endtask

  task automatic idle_inputs();
    reset = 0; Start = 0; Stall = 0; Redirect = 0; RedirectTarget = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          start, stall, redir;
    logic [9:0]  tgt;
    logic [31:0] e_instr;
    logic [9:0]  e_ipc, e_pc;
    bit          e_valid, e_halted;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1,0,0,10'd0, 32'h00, 10'd0, 10'd0, 0, 0}; // Start: RUN, no data yet
    vecs[1]  = '{0,0,0,10'd0, 32'h11, 10'd0, 10'd1, 1, 0};
    vecs[2]  = '{0,0,0,10'd0, 32'h22, 10'd1, 10'd2, 1, 0};
    vecs[3]  = '{0,1,0,10'd0, 32'h22, 10'd1, 10'd2, 1, 0}; // stall x3
    vecs[4]  = '{0,1,0,10'd0, 32'h22, 10'd1, 10'd2, 1, 0};
    vecs[5]  = '{0,1,0,10'd0, 32'h22, 10'd1, 10'd2, 1, 0};
    vecs[6]  = '{0,0,0,10'd0, 32'h33, 10'd2, 10'd3, 1, 0};
    vecs[7]  = '{0,0,0,10'd0, 32'h33, 10'd2, 10'd3, 0, 1}; // halt word at PC3
    vecs[8]  = '{0,1,1,10'd9, 32'h33, 10'd2, 10'd3, 0, 1}; // ignored while halted
    vecs[9]  = '{1,0,0,10'd0, 32'h33, 10'd2, 10'd0, 0, 0}; // restart
    vecs[10] = '{0,0,0,10'd0, 32'h11, 10'd0, 10'd1, 1, 0};
  end

  initial begin
    idle_inputs();
    reset = 1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = HALT;
    step();
    step();
    reset = 0;

    // reset state
    chk("rst.pc",     {22'd0, ProgCounter}, 32'd0);
    chk("rst.instr",  Instr, 32'd0);
    chk("rst.ipc",    {22'd0, InstrPC}, 32'd0);
    chk("rst.valid",  {31'd0, InstrValid}, 32'd0);
    chk("rst.halted", {31'd0, Halted}, 32'd0);
    chk("rst.fcnt",   FetchCount, 32'd0);
    chk("rst.rcnt",   {16'd0, RedirectCount}, 32'd0);

    // table
    for (int v = 0; v < 11; v++) begin
      Start = vecs[v].start; Stall = vecs[v].stall;
      Redirect = vecs[v].redir; RedirectTarget = vecs[v].tgt;
      step();
      $display("vec %0d: pc=%0d instr=%h ipc=%0d valid=%0b halted=%0b",
               v, ProgCounter, Instr, InstrPC, InstrValid, Halted);
      chk($sformatf("vec%0d.instr", v),  Instr, vecs[v].e_instr);
      chk($sformatf("vec%0d.ipc", v),    {22'd0, InstrPC}, {22'd0, vecs[v].e_ipc});
      chk($sformatf("vec%0d.pc", v),     {22'd0, ProgCounter}, {22'd0, vecs[v].e_pc});
      chk($sformatf("vec%0d.valid", v),  {31'd0, InstrValid}, {31'd0, vecs[v].e_valid});
      chk($sformatf("vec%0d.halted", v), {31'd0, Halted}, {31'd0, vecs[v].e_halted});
    end

    // redirect while stalled at PC=5
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 3 * i;
    do_reset();
    Start = 1; step(); Start = 0;
    repeat (5) step();
    chk("pc5.pc", {22'd0, ProgCounter}, 32'd5);
    Stall = 1; Redirect = 1; RedirectTarget = 10'd500;
    step();
    $display("redirect500: pc=%0d valid=%0b", ProgCounter, InstrValid);
    chk("redir.pc",    {22'd0, ProgCounter}, 32'd500);
    chk("redir.valid", {31'd0, InstrValid}, 32'd0);
    Stall = 0; Redirect = 0;
    step();
    $display("after redirect: instr=%h ipc=%0d", Instr, InstrPC);
    chk("redir.instr", Instr, 32'h100 + 3 * 500);
    chk("redir.ipc",   {22'd0, InstrPC}, 32'd500);
    chk("redir.valid1", {31'd0, InstrValid}, 32'd1);
    check_model("redir");

    // wrap from 1023 to 0
    mem[1023] = 32'hAA; mem[0] = 32'hBB;
    Redirect = 1; RedirectTarget = 10'd1023; step(); Redirect = 0;
    step();
    $display("wrap a: instr=%h ipc=%0d", Instr, InstrPC);
    chk("wrap.instr0", Instr, 32'hAA);
    chk("wrap.ipc0",   {22'd0, InstrPC}, 32'd1023);
    step();
    $display("wrap b: instr=%h ipc=%0d", Instr, InstrPC);
    chk("wrap.instr1", Instr, 32'hBB);
    chk("wrap.ipc1",   {22'd0, InstrPC}, 32'd0);
    chk("wrap.pc",     {22'd0, ProgCounter}, 32'd1);
    check_model("wrap");

    // reset mid-run at PC=7, then stay idle until Start
    Redirect = 1; RedirectTarget = 10'd6; step(); Redirect = 0;
    step();
    chk("pc7.pc", {22'd0, ProgCounter}, 32'd7);
    Stall = 1; Redirect = 1; RedirectTarget = 10'd77; reset = 1;
    step();
    reset = 0; Stall = 0; Redirect = 0;
    $display("midrun reset: pc=%0d valid=%0b instr=%h", ProgCounter, InstrValid, Instr);
    chk("mrst.pc",    {22'd0, ProgCounter}, 32'd0);
    chk("mrst.valid", {31'd0, InstrValid}, 32'd0);
    chk("mrst.instr", Instr, 32'd0);
    chk("mrst.ipc",   {22'd0, InstrPC}, 32'd0);
    step(); step();
    chk("idle.pc",    {22'd0, ProgCounter}, 32'd0);
    chk("idle.valid", {31'd0, InstrValid}, 32'd0);
    Start = 1; step(); Start = 0; step();
    $display("resume: instr=%h valid=%0b", Instr, InstrValid);
    chk("resume.instr", Instr, 32'hBB);
    chk("resume.valid", {31'd0, InstrValid}, 32'd1);
    check_model("resume");

    // performance counters: 4 fetches + 2 redirects
    for (int i = 0; i < 1024; i++) mem[i] = 32'h500 + i;
    do_reset();
    Start = 1; step(); Start = 0;
    repeat (4) step();
    Redirect = 1; RedirectTarget = 10'd100; step();
    RedirectTarget = 10'd200; step();
    Redirect = 0;
    $display("perf: fetch=%0d redirect=%0d", FetchCount, RedirectCount);
    chk("perf.fcnt", FetchCount, PERF ? 32'd4 : 32'd0);
    chk("perf.rcnt", {16'd0, RedirectCount}, PERF ? 32'd2 : 32'd0);

    // randomized run against the model
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(15) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(63) == 0);
      Start          = ($urandom_range(3) == 0);
      Stall          = ($urandom_range(3) == 0);
      Redirect       = ($urandom_range(7) == 0);
      RedirectTarget = 10'($urandom);
      step();
      check_model($sformatf("rnd%0d", c));
    end
    $display("random run: %0d cycles, fetch=%0d redirect=%0d", 3000, FetchCount, RedirectCount);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
